// File: rtl/pc_unit.sv
// Fetch-stage program counter with branch/jump redirect, stall hold and an
// internal circular return-address stack with sticky overflow/underflow flags.
// Optional bound check is enabled by defining PC_BOUND_CHECK_EN.
module pc_unit #(
    parameter int unsigned     PC_W      = 8,
    parameter logic [PC_W-1:0] INC       = PC_W'(1),
    parameter logic [PC_W-1:0] RESET_VEC = '0,
    parameter int unsigned     RAS_DEPTH = 4,
    parameter logic [PC_W-1:0] MAX_ADDR  = '1,
    parameter logic [PC_W-1:0] TRAP_VEC  = '0
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           stall,
    input  logic                           branch_taken,
    input  logic [PC_W-1:0]                branch_target,
    input  logic                           jump,
    input  logic [PC_W-1:0]                jump_target,
    input  logic                           call,
    input  logic                           ret,
    output logic [PC_W-1:0]                PC_out,
    output logic                           redirect,
    output logic [$clog2(RAS_DEPTH+1)-1:0] ras_count,
    output logic                           ras_overflow,
    output logic                           ras_underflow,
    output logic                           trap
);

    localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
    localparam int unsigned CNT_W = $clog2(RAS_DEPTH + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(RAS_DEPTH);

    logic [PC_W-1:0]  pc_q, pc_d;
    logic             redirect_q, redirect_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [PTR_W-1:0] ptr_q, ptr_d;        // next free slot; top entry is ptr_q-1
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;
    logic             trap_d;
    logic             push;
    logic [PC_W-1:0]  pc_seq;
    logic [PC_W-1:0]  ras_q [RAS_DEPTH];

    assign pc_seq = pc_q + INC;

    // Next-PC selection and RAS bookkeeping, highest priority first
    always_comb begin
        pc_d       = pc_seq;
        redirect_d = 1'b0;
        cnt_d      = cnt_q;
        ptr_d      = ptr_q;
        ovf_d      = ovf_q;
        unf_d      = unf_q;
        trap_d     = 1'b0;
        push       = 1'b0;

        if (branch_taken) begin
            pc_d       = branch_target;
            redirect_d = 1'b1;
        end else if (stall) begin
            pc_d = pc_q;
        end else if (ret) begin
            if (cnt_q != '0) begin
                pc_d       = ras_q[ptr_q - 1'b1];
                ptr_d      = ptr_q - 1'b1;
                cnt_d      = cnt_q - 1'b1;
                redirect_d = 1'b1;
            end else begin
                unf_d = 1'b1;
            end
        end else if (call) begin
            pc_d       = jump_target;
            push       = 1'b1;
            ptr_d      = ptr_q + 1'b1;
            redirect_d = 1'b1;
            // When full the write slot is the oldest entry, so it is overwritten
            if (cnt_q == CNT_FULL) begin
                ovf_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end else if (jump) begin
            pc_d       = jump_target;
            redirect_d = 1'b1;
        end

`ifdef PC_BOUND_CHECK_EN
        if (pc_d > MAX_ADDR) begin
            pc_d       = TRAP_VEC;
            trap_d     = 1'b1;
            redirect_d = 1'b1;
        end
`endif
    end

    // PC, pointer, count and flag registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q       <= RESET_VEC;
            redirect_q <= 1'b0;
            cnt_q      <= '0;
            ptr_q      <= '0;
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            redirect_q <= redirect_d;
            cnt_q      <= cnt_d;
            ptr_q      <= ptr_d;
            ovf_q      <= ovf_d;
            unf_q      <= unf_d;
        end
    end

    // RAS storage; contents need no reset since the count gates all reads
    always_ff @(posedge clk) begin
        if (!reset && push) begin
            ras_q[ptr_q] <= pc_seq;
        end
    end

`ifdef PC_BOUND_CHECK_EN
    logic trap_q;

    // One-cycle trap pulse on a bound violation
    always_ff @(posedge clk) begin
        if (reset) begin
            trap_q <= 1'b0;
        end else begin
            trap_q <= trap_d;
        end
    end

    assign trap = trap_q;
`else
    logic unused_bound_cfg;
    assign unused_bound_cfg = ^{MAX_ADDR, TRAP_VEC, trap_d};
    assign trap = 1'b0;
`endif

    assign PC_out        = pc_q;
    assign redirect      = redirect_q;
    assign ras_count     = cnt_q;
    assign ras_overflow  = ovf_q;
    assign ras_underflow = unf_q;

endmodule

// File: doc/pc_unit.md
Name: pc_unit

Overview:
Parametrised program counter for the pipelined core's fetch stage. Adds the following over a plain loadable PC:
- sequential increment
- stall hold
- branch redirect
- jump
- call/return through an internal return-address stack (RAS)
- sticky stack error flags

Sits at the front of IF. Drives the instruction memory address and accepts redirects from the EX stage.

Parameters:
PC_W, 8, PC/address width in bits
INC, 1, sequential increment added per non-stalled cycle
RESET_VEC, 0, PC value loaded on reset
RAS_DEPTH, 4, return-address stack entries (power of two, >=2)
MAX_ADDR, 2**PC_W-1, highest legal PC (used only with the optional feature)
TRAP_VEC, 0, PC loaded on bound violation (used only with the optional feature)

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous, active-high reset
stall  in  1  hold PC (IF/ID stall)
branch_taken  in  1  EX-stage branch resolved taken
branch_target  in  PC_W  branch destination
jump  in  1  unconditional jump from ID
jump_target  in  PC_W  jump/call destination
call  in  1  push return address, go to jump_target
ret  in  1  pop return address into PC
PC_out  out  PC_W  current fetch address (registered)
redirect  out  1  registered; high the cycle after any non-sequential PC update
ras_count  out  $clog2(RAS_DEPTH+1)  valid stack entries
ras_overflow  out  1  sticky: push while full
ras_underflow  out  1  sticky: pop while empty
trap  out  1  registered bound-violation pulse (optional feature; tied 0 otherwise)

Behaviour:
- All state updates on the rising clk edge. PC_out changes exactly one cycle after the controlling inputs are sampled.
- Reset (synchronous, highest priority):
  - PC_out=RESET_VEC
  - RAS emptied, ras_count=0
  - ras_overflow=0, ras_underflow=0
  - redirect=0, trap=0
- Reset mid-operation discards all pending inputs in that cycle.
- Next-PC priority, highest first:
  1. branch_taken: PC_out<=branch_target. Overrides stall, ret, call and jump; RAS untouched; redirect<=1.
  2. stall: PC_out holds. jump, call and ret are ignored; RAS untouched; redirect<=0.
  3. ret:
     - RAS non-empty: PC_out<=top entry, pop, redirect<=1.
     - RAS empty: PC_out<=PC_out+INC, ras_underflow<=1, redirect<=0.
  4. call: PC_out<=jump_target, push PC_out+INC, redirect<=1.
     - RAS full: the oldest entry is overwritten (circular buffer), ras_count stays RAS_DEPTH, ras_overflow<=1.
  5. jump: PC_out<=jump_target; redirect<=1.
  6. Otherwise: PC_out<=PC_out+INC; redirect<=0.
- call and ret asserted together: ret wins, no push. jump together with call: call wins.
- Arithmetic: PC_out+INC is modulo 2**PC_W (wrap, no flag). Return addresses are computed the same way.
- RAS: LIFO, pointer arithmetic modulo RAS_DEPTH. ras_count saturates at RAS_DEPTH and never underflows below 0.
- Sticky flags clear only on reset.

Optional Feature:
PC_BOUND_CHECK_EN
- Defined:
  - A computed next PC greater than MAX_ADDR is replaced by TRAP_VEC.
  - trap<=1 for one cycle and redirect<=1.
  - RAS push/pop for that cycle still takes effect.
  - trap resets to 0.
- Undefined: no comparison logic; trap is tied to 0; next PC is used unchanged.

Test Plan:
- Reset: reset=1 for 2 cycles -> PC_out=0, ras_count=0, flags 0. Release, run 3 idle cycles -> PC_out 1,2,3, redirect=0.
- Stall vs branch: PC_out=3, stall=1 two cycles -> PC_out stays 3. stall=1 with branch_taken=1, branch_target=0x40 -> next PC_out=0x40, redirect=1 one cycle.
- Call/ret: PC_out=0x10, call=1, jump_target=0x80 -> PC_out=0x80, ras_count=1. Two idle cycles (0x81, 0x82), ret=1 -> PC_out=0x11, ras_count=0.
- RAS overflow/underflow (RAS_DEPTH=4): 5 consecutive calls -> ras_count=4, ras_overflow=1. 4 rets return the last 4 pushed addresses in reverse order. 5th ret -> PC_out=previous+1, ras_underflow=1.
- Wrap and priority: PC_out=0xFF idle -> PC_out=0x00. call=1 and ret=1 with RAS holding 0x22 -> PC_out=0x22, ras_count decrements, nothing pushed.
- Bound check (PC_BOUND_CHECK_EN, MAX_ADDR=0x7F, TRAP_VEC=0x04): jump to 0x90 -> PC_out=0x04, trap=1 one cycle, redirect=1. Without the macro: PC_out=0x90, trap=0.
